rr_burst_scheduler: RTL and testbench

- Shares one downstream resource (bus, memory port or pipeline slot) among PORTS requesters.
- Grants are held for a multi-beat burst.
- Round-robin fairness uses a one-hot rotating priority pointer.
- A burst ends on a last-beat marker, on the MAX_BURST beat cap, or when the owner abandons its request; the next owner is chosen on the release cycle, with no dead cycle by default.
- Sits between requester FIFOs and the shared resource, sequencing beat-level valid/ready transfers.

---
 rtl/rr_burst_scheduler.sv | 142 ++++++++++++++
 tb/tb_rr_burst_scheduler.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/rr_burst_scheduler.sv
// Round-robin burst arbiter: one owner holds the shared resource for up to MAX_BURST beats.
// Optional macro RR_BURST_SCHED_TURNAROUND_EN inserts a one-cycle GAP after every release.
module rr_burst_scheduler #(
    parameter int PORTS     = 4,
    parameter int MAX_BURST = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [PORTS-1:0]               req,
    input  logic [PORTS-1:0]               req_last,
    input  logic                           out_ready,
    output logic [PORTS-1:0]               grant,
    output logic [$clog2(PORTS)-1:0]       grant_port,
    output logic                           grant_valid,
    output logic                           beat,
    output logic [$clog2(MAX_BURST+1)-1:0] burst_cnt
);

    localparam int PW = $clog2(PORTS);
    localparam int CW = $clog2(MAX_BURST+1);

`ifdef RR_BURST_SCHED_TURNAROUND_EN
    typedef enum logic [1:0] {IDLE, BURST, GAP} state_e;
`else
    typedef enum logic {IDLE, BURST} state_e;
`endif

    state_e         state_q, state_d;
    logic [PORTS-1:0] ptr_q, ptr_d;
    logic [PORTS-1:0] grant_q, grant_d;
    logic [PW-1:0]    port_q, port_d;
    logic             valid_q, valid_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [PORTS-1:0] ptr_rot, ptr_arb, ge_mask, req_hi, pick_vec, win_onehot;
    logic [PW-1:0]    win_idx;
    logic             any_req, at_cap, release_now;

    assign beat        = valid_q & req[port_q] & out_ready;
    assign at_cap      = (cnt_q == CW'(MAX_BURST-1));
    assign release_now = (state_q == BURST) &
                         (~req[port_q] | (beat & (req_last[port_q] | at_cap)));

    // Pointer after release is the owner's one-hot rotated up by one port.
    assign ptr_rot = {grant_q[PORTS-2:0], grant_q[PORTS-1]};
`ifdef RR_BURST_SCHED_TURNAROUND_EN
    assign ptr_arb = ptr_q;
`else
    assign ptr_arb = release_now ? ptr_rot : ptr_q;
`endif

    // ge_mask marks ports at or above the pointer; they win before wrapped ports.
    generate
        for (genvar gi = 0; gi < PORTS; gi++) begin : g_mask
            assign ge_mask[gi] = |ptr_arb[gi:0];
        end
    endgenerate

    assign any_req  = |req;
    assign req_hi   = req & ge_mask;
    assign pick_vec = (|req_hi) ? req_hi : req;

    always_comb begin
        win_idx = '0;
        for (int i = PORTS-1; i >= 0; i--) begin
            if (pick_vec[i]) win_idx = PW'(i);
        end
    end

    assign win_onehot = PORTS'(1) << win_idx;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        port_d  = port_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        case (state_q)
            BURST: begin
                if (release_now) begin
                    ptr_d = ptr_rot;
                    cnt_d = '0;
`ifdef RR_BURST_SCHED_TURNAROUND_EN
                    grant_d = '0;
                    port_d  = '0;
                    valid_d = 1'b0;
                    state_d = GAP;
`else
                    if (any_req) begin
                        grant_d = win_onehot;
                        port_d  = win_idx;
                        valid_d = 1'b1;
                    end else begin
                        grant_d = '0;
                        port_d  = '0;
                        valid_d = 1'b0;
                        state_d = IDLE;
                    end
`endif
                end else if (beat) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                // IDLE and GAP arbitrate identically; GAP simply has nowhere else to go.
                state_d = IDLE;
                if (any_req) begin
                    grant_d = win_onehot;
                    port_d  = win_idx;
                    valid_d = 1'b1;
                    cnt_d   = '0;
                    state_d = BURST;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= PORTS'(1);
            grant_q <= '0;
            port_q  <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            port_q  <= port_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign grant       = grant_q;
    assign grant_port  = port_q;
    assign grant_valid = valid_q;
    assign burst_cnt   = cnt_q;

endmodule

// File: tb/tb_rr_burst_scheduler.sv
// Bench for rr_burst_scheduler: directed scenarios then random traffic, all checked
// against a port-index/arithmetic reference model of the arbitration rules.
module tb_rr_burst_scheduler;

    localparam int P  = 4;
    localparam int MB = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = '0;
    logic [3:0] req_last = '0;
    logic       out_ready = 1'b0;
    logic [3:0] grant;
    logic [1:0] grant_port;
    logic       grant_valid;
    logic       beat;
    logic [2:0] burst_cnt;

    int errors = 0;
    int checks = 0;

    // Reference model: owner index (-1 when nobody holds the grant), pointer index, beat count.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_cnt   = 0;

    rr_burst_scheduler #(.PORTS(P), .MAX_BURST(MB)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .req_last    (req_last),
        .out_ready   (out_ready),
        .grant       (grant),
        .grant_port  (grant_port),
        .grant_valid (grant_valid),
        .beat        (beat),
        .burst_cnt   (burst_cnt)
    );

    always #5 clk = ~clk;

    function automatic int pick(input int ptr, input logic [3:0] r);
        for (int k = 0; k < P; k++) begin
            if (r[(ptr + k) % P]) return (ptr + k) % P;
        end
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge: drive inputs, check outputs against the model, advance one clock.
    task automatic step(input logic [3:0] r, input logic [3:0] l, input logic rdy);
        logic [3:0] exp_grant;
        logic       m_beat;
        logic       rel;
        req = r;
        req_last = l;
        out_ready = rdy;
        #1;
        exp_grant = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
        m_beat = (m_owner >= 0) && r[m_owner] && rdy;
        chk("grant", 32'(grant), 32'(exp_grant));
        chk("grant_valid", 32'(grant_valid), 32'(m_owner >= 0));
        if (m_owner >= 0) chk("grant_port", 32'(grant_port), 32'(m_owner));
        chk("burst_cnt", 32'(burst_cnt), 32'(m_cnt));
        chk("beat", 32'(beat), 32'(m_beat));
        $display("t=%0t req=%b last=%b rdy=%b grant=%b port=%0d cnt=%0d beat=%b",
                 $time, r, l, rdy, grant, grant_port, burst_cnt, beat);
        if (m_owner < 0) begin
            if (r != 4'b0000) begin
                m_owner = pick(m_ptr, r);
                m_cnt = 0;
            end
        end else begin
            rel = !r[m_owner];
            if (m_beat) begin
                m_cnt++;
                if (l[m_owner] || m_cnt == MB) rel = 1'b1;
            end
            if (rel) begin
                m_ptr = (m_owner + 1) % P;
                m_cnt = 0;
`ifdef RR_BURST_SCHED_TURNAROUND_EN
                m_owner = -1;
`else
                m_owner = pick(m_ptr, r);
`endif
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [3:0] r_rand;
        logic [3:0] l_rand;
        logic       rdy_rand;

        // Reset and quiet idle
        repeat (3) @(negedge clk);
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_valid", 32'(grant_valid), 32'h0);
        chk("rst_cnt", 32'(burst_cnt), 32'h0);
        rst_n = 1'b1;
        repeat (10) step(4'b0000, 4'b0000, 1'b1);

        // Two requesters, port 1 ends on its second beat, port 2 takes over
        step(4'b0110, 4'b0000, 1'b1);
        chk("s2_grant_p1", 32'(grant), 32'h2);
        chk("s2_port_p1", 32'(grant_port), 32'h1);
        step(4'b0110, 4'b0000, 1'b1);
        step(4'b0110, 4'b0010, 1'b1);
`ifdef RR_BURST_SCHED_TURNAROUND_EN
        chk("s2_gap", 32'(grant), 32'h0);
        step(4'b0110, 4'b0000, 1'b1);
`endif
        chk("s2_grant_p2", 32'(grant), 32'h4);
        chk("s2_port_p2", 32'(grant_port), 32'h2);
        step(4'b0000, 4'b0000, 1'b1);
        step(4'b0000, 4'b0000, 1'b1);

        // Single requester hits the beat cap and is re-granted
        repeat (4) step(4'b0001, 4'b0000, 1'b1);
        chk("s3_cnt_cap", 32'(burst_cnt), 32'h3);
        step(4'b0001, 4'b0000, 1'b1);
`ifndef RR_BURST_SCHED_TURNAROUND_EN
        chk("s3_regrant", 32'(grant), 32'h1);
        chk("s3_cnt_clr", 32'(burst_cnt), 32'h0);
`endif

        // Stall mid-burst
        step(4'b0001, 4'b0000, 1'b1);
        repeat (5) step(4'b0001, 4'b0000, 1'b0);
        step(4'b0000, 4'b0000, 1'b1);
        step(4'b0000, 4'b0000, 1'b1);

        // Port 3 abandons; pointer wraps to port 0
        step(4'b1000, 4'b0000, 1'b1);
        step(4'b1011, 4'b0000, 1'b1);
        step(4'b0011, 4'b0000, 1'b1);
`ifdef RR_BURST_SCHED_TURNAROUND_EN
        step(4'b0011, 4'b0000, 1'b1);
`endif
        chk("s5_wrap", 32'(grant), 32'h1);
        step(4'b0000, 4'b0000, 1'b1);
        step(4'b0000, 4'b0000, 1'b1);

        // Asynchronous reset between clock edges during a burst
        step(4'b0100, 4'b0000, 1'b1);
        step(4'b0100, 4'b0000, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_grant", 32'(grant), 32'h0);
        chk("arst_valid", 32'(grant_valid), 32'h0);
        chk("arst_cnt", 32'(burst_cnt), 32'h0);
        m_owner = -1;
        m_ptr = 0;
        m_cnt = 0;
        req = 4'b0000;
        @(negedge clk);
        rst_n = 1'b1;
        step(4'b0000, 4'b0000, 1'b1);

        // Random traffic with sticky requests
        r_rand = 4'b0000;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 3) == 0) r_rand = 4'($urandom_range(0, 15));
            l_rand   = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
            rdy_rand = ($urandom_range(0, 3) != 0);
            step(r_rand, l_rand, rdy_rand);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
